// File: rtl/fmap_pkg.sv
// Shared types for the feature-map bank controller.
//   fmap_state_e : bank-rotation FSM states (RUN, PEND, SWAP)
//   bank_idx_w() : width of a bank index for a given bank count
package fmap_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        SWAP = 2'd2
    } fmap_state_e;

    // Bank index width; never narrower than one bit.
    function automatic int unsigned bank_idx_w(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/fmap_bank_ctrl_if.sv
// Feature-map bus between the DMA engines and the bank controller.
//   r_addr*  : read-address burst (crdma -> ctrl), r_addr_ready back
//   r_data*  : read-data burst (ctrl -> crdma), r_data_ready back
//   w_addr*  : write burst with w_data (cwdma -> ctrl), w_addr_ready back
// Modports: master = DMA side, slave = controller side.
interface fmap_bank_ctrl_if #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 8,
    parameter int unsigned DN = 7
);
    localparam int unsigned BW = DN * DW;

    logic [AW-1:0] r_addr;
    logic          r_addr_first;
    logic          r_addr_last;
    logic          r_addr_valid;
    logic          r_addr_ready;

    logic [BW-1:0] r_data;
    logic          r_data_first;
    logic          r_data_last;
    logic          r_data_valid;
    logic          r_data_ready;

    logic [AW-1:0] w_addr;
    logic          w_addr_first;
    logic          w_addr_last;
    logic          w_addr_valid;
    logic          w_addr_ready;
    logic [BW-1:0] w_data;

    modport master (
        output r_addr, r_addr_first, r_addr_last, r_addr_valid,
        input  r_addr_ready,
        input  r_data, r_data_first, r_data_last, r_data_valid,
        output r_data_ready,
        output w_addr, w_addr_first, w_addr_last, w_addr_valid, w_data,
        input  w_addr_ready
    );

    modport slave (
        input  r_addr, r_addr_first, r_addr_last, r_addr_valid,
        output r_addr_ready,
        output r_data, r_data_first, r_data_last, r_data_valid,
        input  r_data_ready,
        input  w_addr, w_addr_first, w_addr_last, w_addr_valid, w_data,
        output w_addr_ready
    );
endinterface

// File: rtl/fmap_bank_sram.sv
// One feature-map bank: 1W1R synchronous RAM, DEPTH words of W bits.
//   clk, rst_n     : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata : write port, committed at the rising edge
//   re/raddr/rdata : read port, rdata updates one edge after re and holds otherwise
module fmap_bank_sram #(
    parameter int unsigned AW    = 14,
    parameter int unsigned W     = 56,
    parameter int unsigned DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[IW'(waddr)] <= wdata;
        end
    end

    // Read register holds its value while re is low so stalled data stays stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[IW'(raddr)];
        end
    end
endmodule

// File: rtl/fmap_bank_ctrl.sv
// Feature-map bank controller: ping-pongs NB banks between the read DMA
// (previous layer output) and the write DMA (current layer output), rotating
// on layer_swap once no burst is in flight.
//   clk, rst_n        : clock, synchronous active-low reset
//   bus (slave)       : read-address, read-data and write bursts
//   layer_swap        : one-cycle pulse requesting a bank rotation
//   rd_bank, wr_bank  : current read/write bank, wr_bank = rd_bank+1 mod NB
//   swap_pending      : rotation requested but not yet applied
//   bound_err         : sticky out-of-range access flag
// Build option: FMAP_BANK_BOUND_CHK_EN enables address range checking;
// without it bound_err is tied low.
module fmap_bank_ctrl
    import fmap_pkg::*;
#(
    parameter int unsigned AW    = 14,
    parameter int unsigned DW    = 8,
    parameter int unsigned DN    = 7,
    parameter int unsigned NB    = 2,
    parameter int unsigned DEPTH = 2**AW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fmap_bank_ctrl_if.slave           bus,
    input  logic                      layer_swap,
    output logic [bank_idx_w(NB)-1:0] rd_bank,
    output logic [bank_idx_w(NB)-1:0] wr_bank,
    output logic                      swap_pending,
    output logic                      bound_err
);
    localparam int unsigned IW     = bank_idx_w(NB);
    localparam int unsigned BEAT_W = DN * DW;

    fmap_state_e state;
    fmap_state_e state_nxt;

    logic              rd_busy, wr_busy;
    logic              rd_busy_nxt, wr_busy_nxt;
    logic              swap_block_c, rotate_c;
    logic              r_acc_c, w_acc_c;
    logic              r_oob_c, w_oob_c;
    logic              rd_oob_q;
    logic [IW-1:0]     rd_sel;
    logic [BEAT_W-1:0] bank_rdata [NB];

    // Handshakes: only burst-opening beats are held off around a rotation.
    assign bus.r_addr_ready = (!bus.r_data_valid || bus.r_data_ready)
                              && !(swap_block_c && bus.r_addr_first);
    assign bus.w_addr_ready = !(swap_block_c && bus.w_addr_first);
    assign r_acc_c          = bus.r_addr_valid && bus.r_addr_ready;
    assign w_acc_c          = bus.w_addr_valid && bus.w_addr_ready;

`ifdef FMAP_BANK_BOUND_CHK_EN
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    assign r_oob_c = {1'b0, bus.r_addr} >= DEPTH_LIM;
    assign w_oob_c = {1'b0, bus.w_addr} >= DEPTH_LIM;

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bound_err <= 1'b0;
        end else if ((r_acc_c && r_oob_c) || (w_acc_c && w_oob_c)) begin
            bound_err <= 1'b1;
        end
    end
`else
    assign r_oob_c   = 1'b0;
    assign w_oob_c   = 1'b0;
    assign bound_err = 1'b0;
`endif

    // Burst tracking; a last beat wins so a first&last beat leaves busy clear.
    always_comb begin
        rd_busy_nxt = rd_busy;
        wr_busy_nxt = wr_busy;
        if (r_acc_c) begin
            if (bus.r_addr_last) begin
                rd_busy_nxt = 1'b0;
            end else if (bus.r_addr_first) begin
                rd_busy_nxt = 1'b1;
            end
        end
        if (w_acc_c) begin
            if (bus.w_addr_last) begin
                wr_busy_nxt = 1'b0;
            end else if (bus.w_addr_first) begin
                wr_busy_nxt = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; pulses outside RUN merge into the pending rotation.
    // PEND looks at next-cycle busy so the rotation follows the closing beat directly.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (layer_swap) begin
                    state_nxt = (rd_busy || wr_busy) ? PEND : SWAP;
                end
            end
            PEND: begin
                if (!rd_busy_nxt && !wr_busy_nxt) begin
                    state_nxt = SWAP;
                end
            end
            SWAP:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // FSM outputs; a swap pulse in RUN also blocks a coinciding first beat.
    always_comb begin
        swap_block_c = 1'b0;
        rotate_c     = 1'b0;
        case (state)
            RUN:  swap_block_c = layer_swap;
            PEND: swap_block_c = 1'b1;
            SWAP: begin
                swap_block_c = 1'b1;
                rotate_c     = 1'b1;
            end
            default: swap_block_c = 1'b1;
        endcase
    end

    // Bank rotation, busy flags and read-data sideband.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_bank          <= '0;
            wr_bank          <= IW'(1);
            rd_busy          <= 1'b0;
            wr_busy          <= 1'b0;
            swap_pending     <= 1'b0;
            bus.r_data_valid <= 1'b0;
            bus.r_data_first <= 1'b0;
            bus.r_data_last  <= 1'b0;
            rd_sel           <= '0;
            rd_oob_q         <= 1'b0;
        end else begin
            rd_busy      <= rd_busy_nxt;
            wr_busy      <= wr_busy_nxt;
            swap_pending <= (state_nxt != RUN);
            if (rotate_c) begin
                rd_bank <= wr_bank;
                wr_bank <= (wr_bank == IW'(NB - 1)) ? '0 : wr_bank + IW'(1);
            end
            if (r_acc_c) begin
                bus.r_data_valid <= 1'b1;
                bus.r_data_first <= bus.r_addr_first;
                bus.r_data_last  <= bus.r_addr_last;
                rd_sel           <= rd_bank;
                rd_oob_q         <= r_oob_c;
            end else if (bus.r_data_ready) begin
                bus.r_data_valid <= 1'b0;
            end
        end
    end

    // rd_sel remembers the source bank so a rotation cannot disturb held data.
    assign bus.r_data = rd_oob_q ? '0 : bank_rdata[rd_sel];

    for (genvar b = 0; b < NB; b++) begin : g_bank
        fmap_bank_sram #(
            .AW    (AW),
            .W     (BEAT_W),
            .DEPTH (DEPTH)
        ) u_sram (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (w_acc_c && !w_oob_c && (wr_bank == IW'(b))),
            .waddr (bus.w_addr),
            .wdata (bus.w_data),
            .re    (r_acc_c && !r_oob_c && (rd_bank == IW'(b))),
            .raddr (bus.r_addr),
            .rdata (bank_rdata[b])
        );
    end
endmodule

// File: tb/tb_fmap_bank_ctrl.sv
// Directed testbench for fmap_bank_ctrl: a 2-bank instance (DEPTH=100) for
// data path, backpressure, swap and range-check scenarios, and a 3-bank
// instance for rotation order and merged swap requests.
module tb_fmap_bank_ctrl;
    localparam int unsigned AW  = 14;
    localparam int unsigned DW  = 8;
    localparam int unsigned DN  = 7;
    localparam int unsigned BW  = DN * DW;
    localparam int unsigned AW3 = 4;

`ifdef FMAP_BANK_BOUND_CHK_EN
    localparam logic        EXP_BERR  = 1'b1;
    localparam int unsigned OOB_WADDR = 130;
`else
    localparam logic        EXP_BERR  = 1'b0;
    localparam int unsigned OOB_WADDR = 120;
`endif

    logic       clk;
    logic       rst_n;
    logic       layer_swap, layer_swap3;
    logic       rd_bank, wr_bank, swap_pending, bound_err;
    logic [1:0] rd_bank3, wr_bank3;
    logic       swap_pending3, bound_err3;

    int n_checks = 0;
    int n_fail   = 0;

    fmap_bank_ctrl_if #(.AW(AW),  .DW(DW), .DN(DN)) bus2 ();
    fmap_bank_ctrl_if #(.AW(AW3), .DW(DW), .DN(DN)) bus3 ();

    fmap_bank_ctrl #(.AW(AW), .DW(DW), .DN(DN), .NB(2), .DEPTH(100)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus2.slave),
        .layer_swap   (layer_swap),
        .rd_bank      (rd_bank),
        .wr_bank      (wr_bank),
        .swap_pending (swap_pending),
        .bound_err    (bound_err)
    );

    fmap_bank_ctrl #(.AW(AW3), .DW(DW), .DN(DN), .NB(3)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus3.slave),
        .layer_swap   (layer_swap3),
        .rd_bank      (rd_bank3),
        .wr_bank      (wr_bank3),
        .swap_pending (swap_pending3),
        .bound_err    (bound_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        layer_swap        = 1'b0;
        layer_swap3       = 1'b0;
        bus2.r_addr       = '0; bus2.r_addr_first = 1'b0; bus2.r_addr_last = 1'b0;
        bus2.r_addr_valid = 1'b0; bus2.r_data_ready = 1'b1;
        bus2.w_addr       = '0; bus2.w_addr_first = 1'b0; bus2.w_addr_last = 1'b0;
        bus2.w_addr_valid = 1'b0; bus2.w_data = '0;
        bus3.r_addr       = '0; bus3.r_addr_first = 1'b0; bus3.r_addr_last = 1'b0;
        bus3.r_addr_valid = 1'b0; bus3.r_data_ready = 1'b1;
        bus3.w_addr       = '0; bus3.w_addr_first = 1'b0; bus3.w_addr_last = 1'b0;
        bus3.w_addr_valid = 1'b0; bus3.w_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL reset_rd_bank: got %0d expected 0", rd_bank); end
        n_checks++; if (wr_bank !== 1'b1) begin n_fail++; $display("FAIL reset_wr_bank: got %0d expected 1", wr_bank); end
        n_checks++; if (bus2.r_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_data_valid: got %b expected 0", bus2.r_data_valid); end
        n_checks++; if (bus2.r_data_first !== 1'b0 || bus2.r_data_last !== 1'b0) begin n_fail++; $display("FAIL reset_first_last: got %b%b expected 00", bus2.r_data_first, bus2.r_data_last); end
        n_checks++; if (bus2.r_data !== '0) begin n_fail++; $display("FAIL reset_r_data: got %0h expected 0", bus2.r_data); end
        n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_swap_pending: got %b expected 0", swap_pending); end
        n_checks++; if (bound_err !== 1'b0) begin n_fail++; $display("FAIL reset_bound_err: got %b expected 0", bound_err); end
        n_checks++; if (bus2.r_addr_ready !== 1'b1 || bus2.w_addr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got r=%b w=%b expected 1 1", bus2.r_addr_ready, bus2.w_addr_ready); end
        n_checks++; if (rd_bank3 !== 2'd0 || wr_bank3 !== 2'd1) begin n_fail++; $display("FAIL reset_nb3_banks: got %0d/%0d expected 0/1", rd_bank3, wr_bank3); end
    endtask

    task automatic test_write_swap_read();
        for (int i = 0; i < 4; i++) begin
            bus2.w_addr       = AW'(i);
            bus2.w_data       = BW'((i + 1) * 17);
            bus2.w_addr_first = (i == 0);
            bus2.w_addr_last  = (i == 3);
            bus2.w_addr_valid = 1'b1;
            #1;
            n_checks++; if (bus2.w_addr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready beat %0d: got %b expected 1", i, bus2.w_addr_ready); end
            tick();
        end
        bus2.w_addr_valid = 1'b0;
        layer_swap = 1'b1;
        tick();
        layer_swap = 1'b0;
        n_checks++; if (swap_pending !== 1'b1 || rd_bank !== 1'b0) begin n_fail++; $display("FAIL swap_state: got pend=%b rd=%0d expected 1 0", swap_pending, rd_bank); end
        tick();
        n_checks++; if (rd_bank !== 1'b1 || wr_bank !== 1'b0 || swap_pending !== 1'b0) begin n_fail++; $display("FAIL swap_done: got rd=%0d wr=%0d pend=%b expected 1 0 0", rd_bank, wr_bank, swap_pending); end
        for (int i = 0; i < 4; i++) begin
            bus2.r_addr       = AW'(i);
            bus2.r_addr_first = (i == 0);
            bus2.r_addr_last  = (i == 3);
            bus2.r_addr_valid = 1'b1;
            #1;
            n_checks++; if (bus2.r_addr_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready beat %0d: got %b expected 1", i, bus2.r_addr_ready); end
            tick();
            n_checks++; if (bus2.r_data_valid !== 1'b1 || bus2.r_data !== BW'((i + 1) * 17)) begin n_fail++; $display("FAIL rd_data beat %0d: got v=%b %0h expected v=1 %0h", i, bus2.r_data_valid, bus2.r_data, (i + 1) * 17); end
            n_checks++; if (bus2.r_data_first !== (i == 0) || bus2.r_data_last !== (i == 3)) begin n_fail++; $display("FAIL rd_flags beat %0d: got %b%b expected %b%b", i, bus2.r_data_first, bus2.r_data_last, i == 0, i == 3); end
        end
        bus2.r_addr_valid = 1'b0;
        tick();
        n_checks++; if (bus2.r_data_valid !== 1'b0) begin n_fail++; $display("FAIL rd_drain: got %b expected 0", bus2.r_data_valid); end
    endtask

    task automatic test_backpressure();
        bus2.r_addr = AW'(0); bus2.r_addr_first = 1'b1; bus2.r_addr_last = 1'b0;
        bus2.r_addr_valid = 1'b1; bus2.r_data_ready = 1'b1;
        tick();
        n_checks++; if (bus2.r_data !== BW'(8'h11)) begin n_fail++; $display("FAIL bp_beat0: got %0h expected 11", bus2.r_data); end
        bus2.r_addr = AW'(1); bus2.r_addr_first = 1'b0;
        bus2.r_data_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (bus2.r_addr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d: got %b expected 0", k, bus2.r_addr_ready); end
            tick();
            n_checks++; if (bus2.r_data_valid !== 1'b1 || bus2.r_data !== BW'(8'h11) || bus2.r_data_first !== 1'b1) begin n_fail++; $display("FAIL bp_hold cycle %0d: got v=%b f=%b %0h expected v=1 f=1 11", k, bus2.r_data_valid, bus2.r_data_first, bus2.r_data); end
        end
        bus2.r_data_ready = 1'b1;
        #1;
        n_checks++; if (bus2.r_addr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b expected 1", bus2.r_addr_ready); end
        tick();
        n_checks++; if (bus2.r_data !== BW'(8'h22) || bus2.r_data_first !== 1'b0) begin n_fail++; $display("FAIL bp_beat1: got %0h f=%b expected 22 f=0", bus2.r_data, bus2.r_data_first); end
        bus2.r_addr = AW'(2); bus2.r_addr_last = 1'b1;
        tick();
        n_checks++; if (bus2.r_data !== BW'(8'h33) || bus2.r_data_last !== 1'b1) begin n_fail++; $display("FAIL bp_beat2: got %0h l=%b expected 33 l=1", bus2.r_data, bus2.r_data_last); end
        bus2.r_addr_valid = 1'b0; bus2.r_addr_last = 1'b0;
        tick();
        n_checks++; if (bus2.r_data_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", bus2.r_data_valid); end
    endtask

    task automatic test_swap_mid_burst();
        int cycles;
        // Single-beat write into bank 0 (the write bank now), read back after rotation.
        bus2.w_addr = AW'(0); bus2.w_data = BW'(8'hA5);
        bus2.w_addr_first = 1'b1; bus2.w_addr_last = 1'b1; bus2.w_addr_valid = 1'b1;
        tick();
        bus2.w_addr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus2.r_addr       = AW'(i);
            bus2.r_addr_first = (i == 0);
            bus2.r_addr_last  = (i == 4);
            bus2.r_addr_valid = 1'b1;
            layer_swap        = (i == 1);
            #1;
            n_checks++; if (bus2.r_addr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready beat %0d: got %b expected 1", i, bus2.r_addr_ready); end
            tick();
            layer_swap = 1'b0;
            if (i < 4) begin
                n_checks++; if (bus2.r_data !== BW'((i + 1) * 17)) begin n_fail++; $display("FAIL mid_data beat %0d: got %0h expected %0h", i, bus2.r_data, (i + 1) * 17); end
            end
            if (i >= 1) begin
                n_checks++; if (swap_pending !== 1'b1 || rd_bank !== 1'b1) begin n_fail++; $display("FAIL mid_pending beat %0d: got pend=%b rd=%0d expected 1 1", i, swap_pending, rd_bank); end
            end
        end
        bus2.r_addr = AW'(0); bus2.r_addr_first = 1'b1; bus2.r_addr_last = 1'b1;
        bus2.r_addr_valid = 1'b1;
        #1;
        n_checks++; if (bus2.r_addr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_first_stall: got %b expected 0", bus2.r_addr_ready); end
        cycles = 0;
        while (rd_bank !== 1'b0 && cycles < 10) begin
            tick();
            cycles++;
        end
        n_checks++; if (cycles !== 1) begin n_fail++; $display("FAIL mid_rotate_delay: got %0d cycles expected 1", cycles); end
        n_checks++; if (wr_bank !== 1'b1 || swap_pending !== 1'b0) begin n_fail++; $display("FAIL mid_after_rotate: got wr=%0d pend=%b expected 1 0", wr_bank, swap_pending); end
        n_checks++; if (bus2.r_addr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_first_release: got %b expected 1", bus2.r_addr_ready); end
        tick();
        bus2.r_addr_valid = 1'b0;
        n_checks++; if (bus2.r_data !== BW'(8'hA5) || bus2.r_data_valid !== 1'b1) begin n_fail++; $display("FAIL mid_new_bank_data: got v=%b %0h expected v=1 a5", bus2.r_data_valid, bus2.r_data); end
        tick();
    endtask

    task automatic test_bound();
        // rd_bank=0, wr_bank=1 here.
        bus2.w_addr = AW'(2); bus2.w_data = BW'(8'h5A);
        bus2.w_addr_first = 1'b1; bus2.w_addr_last = 1'b1; bus2.w_addr_valid = 1'b1;
        tick();
        n_checks++; if (bound_err !== 1'b0) begin n_fail++; $display("FAIL bound_inrange: got %b expected 0", bound_err); end
        bus2.w_addr = AW'(OOB_WADDR); bus2.w_data = BW'(8'hEE);
        tick();
        bus2.w_addr_valid = 1'b0;
        n_checks++; if (bound_err !== EXP_BERR) begin n_fail++; $display("FAIL bound_wr_err: got %b expected %b", bound_err, EXP_BERR); end
        layer_swap = 1'b1;
        tick();
        layer_swap = 1'b0;
        tick();
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL bound_swap: got %0d expected 1", rd_bank); end
        bus2.r_addr = AW'(2); bus2.r_addr_first = 1'b1; bus2.r_addr_last = 1'b1;
        bus2.r_addr_valid = 1'b1;
        tick();
        n_checks++; if (bus2.r_data !== BW'(8'h5A)) begin n_fail++; $display("FAIL bound_no_alias: got %0h expected 5a", bus2.r_data); end
        bus2.r_addr = AW'(120);
        tick();
        bus2.r_addr_valid = 1'b0;
        n_checks++; if (bus2.r_data_valid !== 1'b1) begin n_fail++; $display("FAIL bound_rd_valid: got %b expected 1", bus2.r_data_valid); end
`ifdef FMAP_BANK_BOUND_CHK_EN
        n_checks++; if (bus2.r_data !== '0) begin n_fail++; $display("FAIL bound_rd_zero: got %0h expected 0", bus2.r_data); end
`endif
        tick();
        n_checks++; if (bound_err !== EXP_BERR) begin n_fail++; $display("FAIL bound_sticky: got %b expected %b", bound_err, EXP_BERR); end
    endtask

    task automatic test_nb3_rotation();
        logic [1:0] exp_rd [3] = '{2'd1, 2'd2, 2'd0};
        for (int s = 0; s < 3; s++) begin
            layer_swap3 = 1'b1;
            tick();
            // Third request is held into the SWAP cycle: must still rotate once.
            layer_swap3 = (s == 2);
            tick();
            layer_swap3 = 1'b0;
            tick();
            n_checks++; if (rd_bank3 !== exp_rd[s] || wr_bank3 !== ((exp_rd[s] == 2'd2) ? 2'd0 : exp_rd[s] + 2'd1)) begin n_fail++; $display("FAIL nb3_rotate %0d: got rd=%0d wr=%0d expected rd=%0d", s, rd_bank3, wr_bank3, exp_rd[s]); end
        end
        // Open a write burst, then request rotation three times while it is in flight.
        bus3.w_addr = AW3'(0); bus3.w_data = BW'(8'h99);
        bus3.w_addr_first = 1'b1; bus3.w_addr_last = 1'b0; bus3.w_addr_valid = 1'b1;
        tick();
        bus3.w_addr_valid = 1'b0;
        layer_swap3 = 1'b1;
        tick();
        n_checks++; if (swap_pending3 !== 1'b1 || rd_bank3 !== 2'd0) begin n_fail++; $display("FAIL nb3_pend: got pend=%b rd=%0d expected 1 0", swap_pending3, rd_bank3); end
        tick();
        tick();
        layer_swap3 = 1'b0;
        n_checks++; if (swap_pending3 !== 1'b1 || rd_bank3 !== 2'd0) begin n_fail++; $display("FAIL nb3_pend_hold: got pend=%b rd=%0d expected 1 0", swap_pending3, rd_bank3); end
        bus3.w_addr = AW3'(1); bus3.w_addr_first = 1'b0; bus3.w_addr_last = 1'b1;
        bus3.w_addr_valid = 1'b1;
        #1;
        n_checks++; if (bus3.w_addr_ready !== 1'b1) begin n_fail++; $display("FAIL nb3_inflight_ready: got %b expected 1", bus3.w_addr_ready); end
        tick();
        bus3.w_addr_valid = 1'b0;
        tick();
        n_checks++; if (rd_bank3 !== 2'd1 || wr_bank3 !== 2'd2 || swap_pending3 !== 1'b0) begin n_fail++; $display("FAIL nb3_merged: got rd=%0d wr=%0d pend=%b expected 1 2 0", rd_bank3, wr_bank3, swap_pending3); end
        repeat (2) tick();
        n_checks++; if (rd_bank3 !== 2'd1) begin n_fail++; $display("FAIL nb3_single: got rd=%0d expected 1", rd_bank3); end
    endtask

    task automatic test_reset_mid_burst();
        bus2.r_addr = AW'(0); bus2.r_addr_first = 1'b1; bus2.r_addr_last = 1'b0;
        bus2.r_addr_valid = 1'b1;
        tick();
        bus2.r_addr_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (bus2.r_data_valid !== 1'b0 || bus2.r_data !== '0) begin n_fail++; $display("FAIL rstmid_data: got v=%b %0h expected v=0 0", bus2.r_data_valid, bus2.r_data); end
        n_checks++; if (rd_bank !== 1'b0 || wr_bank !== 1'b1 || swap_pending !== 1'b0 || bound_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got rd=%0d wr=%0d pend=%b berr=%b expected 0 1 0 0", rd_bank, wr_bank, swap_pending, bound_err); end
        tick();
        n_checks++; if (bus2.r_data_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_output: got %b expected 0", bus2.r_data_valid); end
    endtask

    initial begin
        test_reset();
        test_write_swap_read();
        test_backpressure();
        test_swap_mid_burst();
        test_bound();
        test_nb3_rotation();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
